// File: rtl/camera_test_pattern.sv
// Raw RGGB Bayer test-pattern source with sensor-like frame/line blanking.
// States: IDLE wait | FRONT fv before line 0 | LINE active px | HBLANK line gap | BACK fv after last line | VBLANK fv low
module camera_test_pattern #(
    parameter int X_SIZE  = 1280,
    parameter int Y_SIZE  = 720,
    parameter int H_BLANK = 32,
    parameter int V_FRONT = 16,
    parameter int V_BACK  = 16,
    parameter int V_BLANK = 64
) (
    input  logic        clock_pixel_in,
    input  logic        reset_pixel_n_in,
    input  logic        start_in,
    input  logic        continuous_in,
    input  logic [1:0]  pattern_select_in,
    output logic        frame_valid_out,
    output logic        line_valid_out,
    output logic [9:0]  pixel_data_out,
    output logic        busy_out,
    output logic [15:0] frame_count_out
);

    localparam int XW  = $clog2(X_SIZE);
    localparam int YW  = $clog2(Y_SIZE);
    localparam int BW  = X_SIZE / 8;
    localparam int BWW = $clog2(BW);

    localparam logic [XW-1:0]  X_LAST    = XW'(X_SIZE - 1);
    localparam logic [YW-1:0]  Y_LAST    = YW'(Y_SIZE - 1);
    localparam logic [BWW-1:0] BW_LAST   = BWW'(BW - 1);
    localparam logic [15:0]    FRONT_LD  = 16'(V_FRONT - 1);
    localparam logic [15:0]    HBLANK_LD = 16'(H_BLANK - 1);
    localparam logic [15:0]    BACK_LD   = 16'(V_BACK - 1);
    localparam logic [15:0]    VBLANK_LD = 16'(V_BLANK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRONT,
        S_LINE,
        S_HBLANK,
        S_BACK,
        S_VBLANK
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [BWW-1:0] bw_q, bw_d;
    logic [2:0]     bar_q, bar_d;
    logic [1:0]     pat_q, pat_d;
    logic [15:0]    fc_q, fc_d;

    logic           fv_q, lv_q, busy_q;
    logic [9:0]     pix_q;
    logic [9:0]     px_d;
    logic [2:0]     bar_code;
    logic           site_r, site_b, bar_on;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        bw_d    = bw_q;
        bar_d   = bar_q;
        pat_d   = pat_q;
        fc_d    = fc_q;

        case (state_q)
            S_IDLE: begin
                if (start_in || continuous_in) begin
                    state_d = S_FRONT;
                    cnt_d   = FRONT_LD;
                    pat_d   = pattern_select_in;
                end
            end
            S_FRONT: begin
                if (cnt_q == '0) begin
                    state_d = S_LINE;
                    x_d     = '0;
                    y_d     = '0;
                    bw_d    = '0;
                    bar_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_LINE: begin
                if (x_q == X_LAST) begin
                    if (y_q == Y_LAST) begin
                        state_d = S_BACK;
                        cnt_d   = BACK_LD;
                    end else begin
                        state_d = S_HBLANK;
                        cnt_d   = HBLANK_LD;
                    end
                end else begin
                    x_d = x_q + XW'(1);
                    // Bar index tracked by a width counter; the last bar absorbs any remainder.
                    if (bw_q == BW_LAST) begin
                        bw_d = '0;
                        if (bar_q != 3'd7) begin
                            bar_d = bar_q + 3'd1;
                        end
                    end else begin
                        bw_d = bw_q + BWW'(1);
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == '0) begin
                    state_d = S_LINE;
                    x_d     = '0;
                    y_d     = y_q + YW'(1);
                    bw_d    = '0;
                    bar_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_BACK: begin
                if (cnt_q == '0) begin
                    state_d = S_VBLANK;
                    cnt_d   = VBLANK_LD;
                    fc_d    = fc_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_VBLANK: begin
                if (cnt_q == '0) begin
                    if (continuous_in) begin
                        state_d = S_FRONT;
                        cnt_d   = FRONT_LD;
                        pat_d   = pattern_select_in;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        site_r   = !y_d[0] && !x_d[0];
        site_b   = y_d[0] && x_d[0];
        bar_code = 3'd7 - bar_d;
        if (site_r) begin
            bar_on = bar_code[2];
        end else if (site_b) begin
            bar_on = bar_code[0];
        end else begin
            bar_on = bar_code[1];
        end

        case (pat_d)
            2'd0: begin
                if (site_r) begin
                    px_d = 10'h3FF;
                end else if (site_b) begin
                    px_d = 10'h000;
                end else begin
                    px_d = 10'h200;
                end
            end
            2'd1: px_d = 10'(x_d);
            2'd2: px_d = bar_on ? 10'h3FF : 10'h000;
            default: px_d = 10'(x_d) + 10'(y_d) + fc_q[9:0];
        endcase
    end

    always_ff @(posedge clock_pixel_in) begin
        if (!reset_pixel_n_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            bw_q    <= '0;
            bar_q   <= '0;
            pat_q   <= '0;
            fc_q    <= '0;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            pix_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bw_q    <= bw_d;
            bar_q   <= bar_d;
            pat_q   <= pat_d;
            fc_q    <= fc_d;
            // Outputs are registered from the next state so they line up with state_q.
            fv_q    <= (state_d == S_FRONT) || (state_d == S_LINE) ||
                       (state_d == S_HBLANK) || (state_d == S_BACK);
            lv_q    <= (state_d == S_LINE);
            pix_q   <= (state_d == S_LINE) ? px_d : 10'h000;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign frame_valid_out = fv_q;
    assign line_valid_out  = lv_q;
    assign pixel_data_out  = pix_q;
    assign busy_out        = busy_q;
    assign frame_count_out = fc_q;

endmodule
